// File: rtl/ttt_move_gen.sv
// Tic-tac-toe computer move generator: scans latched boards for a win, then a block,
// then a positional preference, one candidate per clock, answering via req/valid.
module ttt_move_gen #(
  parameter bit WIN_EN   = 1'b1,
  parameter bit BLOCK_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req,
  input  logic [8:0] i_player_board,
  input  logic [8:0] i_computer_board,
  output logic       o_busy,
  output logic       o_move_valid,
  output logic [3:0] o_move_idx,
  output logic [8:0] o_move_onehot,
  output logic       o_no_move,
  output logic       o_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WIN   = 3'd1;
  localparam logic [2:0] ST_BLOCK = 3'd2;
  localparam logic [2:0] ST_PREF  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [2:0] ST_FIRST     = WIN_EN ? ST_WIN : (BLOCK_EN ? ST_BLOCK : ST_PREF);
  localparam logic [2:0] ST_AFTER_WIN = BLOCK_EN ? ST_BLOCK : ST_PREF;

  // Three cell indices of line k, packed {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] k);
    case (k)
      3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
      3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
      3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
      3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
      3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
      default: line_cells = {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] k);
    case (k)
      4'd0:    pref_cell = 4'd4;
      4'd1:    pref_cell = 4'd0;
      4'd2:    pref_cell = 4'd2;
      4'd3:    pref_cell = 4'd6;
      4'd4:    pref_cell = 4'd8;
      4'd5:    pref_cell = 4'd1;
      4'd6:    pref_cell = 4'd3;
      4'd7:    pref_cell = 4'd5;
      default: pref_cell = 4'd7;
    endcase
  endfunction

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [8:0] r_p;
  logic [8:0] r_c;
  logic [3:0] r_move_idx;
  logic [8:0] r_move_onehot;
  logic       r_no_move;
  logic       r_err;

  logic [2:0]  w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [8:0]  w_p_nxt;
  logic [8:0]  w_c_nxt;
  logic [3:0]  w_move_idx_nxt;
  logic [8:0]  w_move_onehot_nxt;
  logic        w_no_move_nxt;
  logic        w_err_nxt;

  logic [8:0]  w_empty;
  logic [8:0]  w_own;
  logic        w_overlap;
  logic [11:0] w_line;
  logic [3:0]  w_a;
  logic [3:0]  w_b;
  logic [3:0]  w_c3;
  logic        w_hit_ab;
  logic        w_hit_ac;
  logic        w_hit_bc;
  logic        w_hit;
  logic [3:0]  w_hit_cell;
  logic [3:0]  w_pref;

  assign w_empty   = ~(r_p | r_c);
  assign w_own     = (r_state == ST_BLOCK) ? r_p : r_c;
  assign w_overlap = |(r_p & r_c);
  assign w_line    = line_cells(r_cnt[2:0]);
  assign w_a       = w_line[11:8];
  assign w_b       = w_line[7:4];
  assign w_c3      = w_line[3:0];

  // A hit is two owned cells plus an empty third; the empty one is the move.
  assign w_hit_ab   = w_own[w_a] & w_own[w_b] & w_empty[w_c3];
  assign w_hit_ac   = w_own[w_a] & w_own[w_c3] & w_empty[w_b];
  assign w_hit_bc   = w_own[w_b] & w_own[w_c3] & w_empty[w_a];
  assign w_hit      = w_hit_ab | w_hit_ac | w_hit_bc;
  assign w_hit_cell = w_hit_ab ? w_c3 : (w_hit_ac ? w_b : w_a);
  assign w_pref     = pref_cell(r_cnt);

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_p_nxt           = r_p;
    w_c_nxt           = r_c;
    w_move_idx_nxt    = r_move_idx;
    w_move_onehot_nxt = r_move_onehot;
    w_no_move_nxt     = r_no_move;
    w_err_nxt         = r_err;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_p_nxt           = i_player_board;
          w_c_nxt           = i_computer_board;
          w_cnt_nxt         = 4'd0;
          w_move_idx_nxt    = 4'd0;
          w_move_onehot_nxt = 9'd0;
          w_no_move_nxt     = 1'b0;
          w_err_nxt         = 1'b0;
          w_state_nxt       = ST_FIRST;
        end
      end
      ST_WIN, ST_BLOCK: begin
        if (w_overlap) begin
          w_err_nxt     = 1'b1;
          w_no_move_nxt = 1'b1;
          w_state_nxt   = ST_RESP;
        end else if (w_hit) begin
          w_move_idx_nxt    = w_hit_cell;
          w_move_onehot_nxt = 9'd1 << w_hit_cell;
          w_state_nxt       = ST_RESP;
        end else if (r_cnt == 4'd7) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = (r_state == ST_WIN) ? ST_AFTER_WIN : ST_PREF;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_PREF: begin
        if (w_overlap) begin
          w_err_nxt     = 1'b1;
          w_no_move_nxt = 1'b1;
          w_state_nxt   = ST_RESP;
        end else if (w_empty[w_pref]) begin
          w_move_idx_nxt    = w_pref;
          w_move_onehot_nxt = 9'd1 << w_pref;
          w_state_nxt       = ST_RESP;
        end else if (r_cnt == 4'd8) begin
          w_no_move_nxt = 1'b1;
          w_state_nxt   = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_RESP: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_p           <= 9'd0;
      r_c           <= 9'd0;
      r_move_idx    <= 4'd0;
      r_move_onehot <= 9'd0;
      r_no_move     <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_p           <= w_p_nxt;
      r_c           <= w_c_nxt;
      r_move_idx    <= w_move_idx_nxt;
      r_move_onehot <= w_move_onehot_nxt;
      r_no_move     <= w_no_move_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign o_busy        = (r_state == ST_WIN) || (r_state == ST_BLOCK) || (r_state == ST_PREF);
  assign o_move_valid  = (r_state == ST_RESP);
  assign o_move_idx    = r_move_idx;
  assign o_move_onehot = r_move_onehot;
  assign o_no_move     = r_no_move;
  assign o_err         = r_err;

endmodule
